// File: rtl/raster_scan_ctrl_pkg.sv
// Shared types and defaults for the raster scan sequencer.
package raster_pkg;

  localparam int W = 4;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } scan_state_t;

  typedef logic [W-1:0] coord_t;

endpackage

// File: rtl/raster_scan_ctrl_if.sv
// Coordinate stream from the scan sequencer to a pixel consumer (valid/ready).
interface raster_scan_ctrl_if #(
  parameter int W = raster_pkg::W
) ();

  logic         valid;
  logic         ready;
  logic         last;
  logic [W-1:0] x;
  logic [W-1:0] y;

  modport master (output valid, output x, output y, output last, input ready);
  modport slave  (input valid, input x, input y, input last, output ready);

endinterface

// File: rtl/raster_axis_counter.sv
// Loadable bounded axis counter; incrementing at max reloads min instead of wrapping.
module raster_axis_counter #(
  parameter int W = raster_pkg::W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         inc,
  input  logic [W-1:0] min,
  input  logic [W-1:0] max,
  output logic [W-1:0] cnt,
  output logic         at_max
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Compare before incrementing so max = all-ones never needs a wrap.
  assign at_max = (cnt_q == max);
  assign cnt    = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = min;
    end else if (inc) begin
      cnt_d = at_max ? min : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/raster_scan_ctrl.sv
// Start/stall/abort-controlled row-major scan of a programmable window.
module raster_scan_ctrl
  import raster_pkg::*;
#(
  parameter int W = raster_pkg::W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  input  logic [W-1:0]        x_min,
  input  logic [W-1:0]        x_max,
  input  logic [W-1:0]        y_min,
  input  logic [W-1:0]        y_max,
  raster_scan_ctrl_if.master  bus,
  output logic                busy,
  output logic                done,
  output logic                err
);

  scan_state_t  state_q, state_d;
  logic [W-1:0] x_min_q, x_min_d, x_max_q, x_max_d;
  logic [W-1:0] y_min_q, y_min_d, y_max_q, y_max_d;
  logic         err_q, err_d;

  logic         win_ok, load, xfer, at_last, inc_x, inc_y;
  logic         x_at_max, y_at_max;
  logic [W-1:0] x_cnt, y_cnt, x_lo, y_lo;

  assign win_ok  = (x_min <= x_max) && (y_min <= y_max);
  assign load    = (state_q == IDLE) && start && win_ok;
  assign xfer    = (state_q == SCAN) && bus.ready;
  assign at_last = x_at_max && y_at_max;
  // The final beat leaves the counters parked on (x_max, y_max).
  assign inc_x   = xfer && !at_last;
  assign inc_y   = inc_x && x_at_max;
  assign x_lo    = load ? x_min : x_min_q;
  assign y_lo    = load ? y_min : y_min_q;

  always_comb begin
    state_d = state_q;
    x_min_d = x_min_q;
    x_max_d = x_max_q;
    y_min_d = y_min_q;
    y_max_d = y_max_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (win_ok) begin
            x_min_d = x_min;
            x_max_d = x_max;
            y_min_d = y_min;
            y_max_d = y_max;
            state_d = SCAN;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      SCAN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (xfer && at_last) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      x_min_q <= '0;
      x_max_q <= '0;
      y_min_q <= '0;
      y_max_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_min_q <= x_min_d;
      x_max_q <= x_max_d;
      y_min_q <= y_min_d;
      y_max_q <= y_max_d;
      err_q   <= err_d;
    end
  end

  raster_axis_counter #(.W(W)) u_x_cnt (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .inc    (inc_x),
    .min    (x_lo),
    .max    (x_max_q),
    .cnt    (x_cnt),
    .at_max (x_at_max)
  );

  raster_axis_counter #(.W(W)) u_y_cnt (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .inc    (inc_y),
    .min    (y_lo),
    .max    (y_max_q),
    .cnt    (y_cnt),
    .at_max (y_at_max)
  );

  assign bus.valid = (state_q == SCAN);
  assign bus.x     = x_cnt;
  assign bus.y     = y_cnt;
  assign bus.last  = (state_q == SCAN) && at_last;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign err       = err_q;

endmodule

// File: tb/tb_raster_scan_ctrl.sv
// Scoreboard bench: stimulus queues expected beats/pulses, a negedge monitor pops and compares.
module tb_raster_scan_ctrl;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [CW-1:0] x_min = '0, x_max = '0, y_min = '0, y_max = '0;
  logic          busy, done, err;

  raster_scan_ctrl_if #(.W(CW)) bus ();

  raster_scan_ctrl #(.W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .abort (abort),
    .x_min (x_min),
    .x_max (x_max),
    .y_min (y_min),
    .y_max (y_max),
    .bus   (bus),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
    bit last;
  } beat_t;

  beat_t exp_q[$];
  bit    done_q[$];
  bit    err_q[$];

  int vectors     = 0;
  int miscompares = 0;
  int beats_seen  = 0;
  int ready_mode  = 1;  // 0: never, 1: always, 2: 1,0,0 pattern, 3: random

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the window is walked row by row, x fastest.
  task automatic push_window(input int xmn, input int xmx, input int ymn, input int ymx, input int limit);
    int n = 0;
    for (int yy = ymn; yy <= ymx; yy++) begin
      for (int xx = xmn; xx <= xmx; xx++) begin
        beat_t b;
        if (n < limit) begin
          b.x = xx;
          b.y = yy;
          b.last = (xx == xmx) && (yy == ymx);
          exp_q.push_back(b);
        end
        n++;
      end
    end
  endtask

  // mode 0: invalid window (expect err), 1: scan to completion, 2: scan without done
  task automatic issue_start(input int xmn, input int xmx, input int ymn, input int ymx, input int mode);
    @(posedge clk);
    #2;
    if (mode == 0) err_q.push_back(1'b1);
    else push_window(xmn, xmx, ymn, ymx, 1 << 30);
    if (mode == 1) done_q.push_back(1'b1);
    x_min = CW'(xmn); x_max = CW'(xmx); y_min = CW'(ymn); y_max = CW'(ymx);
    start = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    x_min = CW'($urandom); x_max = CW'($urandom); y_min = CW'($urandom); y_max = CW'($urandom);
    @(negedge clk);
    check("start_valid", bus.valid, (mode != 0));
    if (mode != 0) begin
      check("start_x", bus.x, xmn);
      check("start_y", bus.y, ymn);
    end
    $display("start window x %0d..%0d y %0d..%0d mode %0d", xmn, xmx, ymn, ymx, mode);
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 3000 && busy; k++) @(negedge clk);
    check("scan_finished_in_budget", busy, 0);
    @(negedge clk);
  endtask

  // Consumer ready driver
  initial begin
    int pat = 0;
    bus.ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0:       bus.ready = 1'b0;
        1:       bus.ready = 1'b1;
        2:       bus.ready = (pat % 3 == 0);
        default: bus.ready = 1'($urandom);
      endcase
      pat++;
    end
  end

  // Monitor / scoreboard
  initial begin
    beat_t b;
    bit    dummy;
    bit    prev_done = 0, prev_err = 0, prev_hold = 0;
    logic [CW-1:0] hx, hy;
    int    cyc = 0, last_beat_cyc = -10;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        prev_done = 0; prev_err = 0; prev_hold = 0;
      end else begin
        if (prev_hold && bus.valid) begin
          check("hold_x", bus.x, hx);
          check("hold_y", bus.y, hy);
        end
        prev_hold = bus.valid && !bus.ready;
        hx = bus.x;
        hy = bus.y;
        if (!bus.valid) check("last_unqualified", bus.last, 0);
        if (bus.valid && bus.ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_beat", 1, 0);
          end else begin
            b = exp_q.pop_front();
            $display("beat (%0d,%0d) last=%0b expected (%0d,%0d) last=%0b",
                     bus.x, bus.y, bus.last, b.x, b.y, b.last);
            check("beat_x", bus.x, b.x);
            check("beat_y", bus.y, b.y);
            check("beat_last", bus.last, b.last);
            if (b.last) last_beat_cyc = cyc;
          end
          beats_seen++;
        end
        if (done) begin
          if (done_q.size() == 0) begin
            check("unexpected_done", 1, 0);
          end else begin
            dummy = done_q.pop_front();
            check("done_beats_remaining", exp_q.size(), 0);
            check("done_latency", cyc, last_beat_cyc + 1);
            check("done_valid", bus.valid, 0);
            check("done_busy", busy, 1);
          end
        end
        if (prev_done) begin
          check("busy_fall", busy, 0);
          check("done_width", done, 0);
        end
        prev_done = done;
        if (err) begin
          if (err_q.size() == 0) begin
            check("unexpected_err", 1, 0);
          end else begin
            dummy = err_q.pop_front();
            check("err_valid", bus.valid, 0);
            check("err_busy", busy, 0);
          end
        end
        if (prev_err) check("err_width", err, 0);
        prev_err = err;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int k;
    int a, b2, c, d;
    repeat (3) @(negedge clk);
    check("rst_valid", bus.valid, 0);
    check("rst_busy", busy, 0);
    check("rst_last", bus.last, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_x", bus.x, 0);
    check("rst_y", bus.y, 0);
    reset = 1'b0;

    // Full frame, consumer always ready
    ready_mode = 1;
    issue_start(0, 15, 0, 15, 1);
    wait_idle();

    // Sub-window with stalls
    ready_mode = 2;
    issue_start(2, 4, 1, 2, 1);
    wait_idle();

    // Invalid window, then a normal scan
    ready_mode = 1;
    issue_start(5, 3, 0, 0, 0);
    check("invalid_valid", bus.valid, 0);
    check("invalid_busy", busy, 0);
    wait_idle();
    issue_start(1, 2, 3, 3, 1);
    wait_idle();

    // Single pixel
    issue_start(7, 7, 9, 9, 1);
    wait_idle();

    // Abort after 20 beats; a start mid-scan must be ignored
    ready_mode = 1;
    @(posedge clk);
    @(posedge clk);
    #2;
    push_window(0, 15, 0, 15, 20);
    x_min = 0; x_max = 15; y_min = 0; y_max = 15;
    start = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    x_min = 9; x_max = 9; y_min = 9; y_max = 9;
    start = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    repeat (14) @(posedge clk);
    #2;
    abort = 1'b1;
    @(posedge clk);
    #2;
    abort = 1'b0;
    @(negedge clk);
    check("abort_valid", bus.valid, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_beats_consumed", exp_q.size(), 0);
    repeat (3) @(negedge clk);
    $display("abort after 20 beats");

    // Reset asserted between clock edges at beat 40
    base = beats_seen;
    issue_start(0, 15, 0, 15, 2);
    k = 0;
    while (beats_seen < base + 40 && k < 1000) begin
      @(posedge clk);
      k++;
    end
    check("reset_scan_progress", (beats_seen >= base + 40), 1);
    #3;
    reset = 1'b1;
    #1;
    check("midrst_x", bus.x, 0);
    check("midrst_y", bus.y, 0);
    check("midrst_valid", bus.valid, 0);
    check("midrst_busy", busy, 0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    $display("reset mid-scan");
    issue_start(3, 5, 6, 6, 1);
    wait_idle();

    // Randomized windows with random backpressure
    ready_mode = 3;
    for (int i = 0; i < 12; i++) begin
      a = $urandom_range(15); b2 = $urandom_range(15);
      c = $urandom_range(15); d = $urandom_range(15);
      if ($urandom_range(3) != 0) begin
        if (a > b2) begin k = a; a = b2; b2 = k; end
        if (c > d) begin k = c; c = d; d = k; end
      end
      issue_start(a, b2, c, d, (a <= b2 && c <= d) ? 1 : 0);
      wait_idle();
    end

    repeat (3) @(negedge clk);
    check("beats_left", exp_q.size(), 0);
    check("done_left", done_q.size(), 0);
    check("err_left", err_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/raster_scan_ctrl.md
# raster_scan_ctrl

Sequencer for the 16×16 raster coordinate datapath. On a `start` request it walks a programmable rectangular window in row-major order: x is the inner loop and y the outer loop. It presents each (x, y) coordinate to a downstream pixel consumer over a valid/ready handshake, then reports completion. It sits between the frame-level control logic and the per-pixel consumers, replacing free-running raster counting with a start/stall/abort-controlled scan.

## Interface
- `W`, default 4: coordinate width; the raster is 2^W × 2^W.
- `clk` input 1: single clock; all state updates on its rising edge.
- `reset` input 1: asynchronous, active-high; forces IDLE and zeroes all outputs immediately.
- `start` input 1: scan request; sampled only in IDLE.
- `abort` input 1: synchronous cancel of an active scan.
- `x_min`, `x_max` input W: inclusive horizontal window bounds; latched on accepted `start`.
- `y_min`, `y_max` input W: inclusive vertical window bounds; latched on accepted `start`.
- `ready` input 1: consumer accepts the current coordinate.
- `valid` output 1: `x`/`y` hold a coordinate to be consumed.
- `x`, `y` output W: current coordinate.
- `last` output 1: current coordinate is (x_max, y_max); qualified by `valid`.
- `busy` output 1: high in SCAN and DONE.
- `done` output 1: one-cycle pulse after the final beat is accepted.
- `err` output 1: one-cycle pulse when `start` carries an invalid window.

## Operation
- States: IDLE, SCAN, DONE.
- IDLE:
  - `start`=1 with `x_min`≤`x_max` and `y_min`≤`y_max`: latch the bounds, load x=`x_min`, y=`y_min`, go to SCAN.
  - `start`=1 with either min>max: pulse `err` for one cycle, stay in IDLE, latch nothing.
- SCAN:
  - `valid`=1 throughout.
  - A beat transfers on a clock edge where `valid`&&`ready`.
  - Without a transfer, `x`, `y` and `last` hold.
  - On transfer with x<x_max: x←x+1.
  - On transfer with x=x_max and y<y_max: x←x_min, y←y+1.
  - On transfer with `last`=1: go to DONE.
- Comparisons are made against the latched bounds before any increment, so x_max=2^W−1 never overflows and there is no reliance on counter wrap.
- DONE: `done`=1 and `valid`=0 for exactly one cycle, then IDLE.
- `abort`=1 in SCAN or DONE: return to IDLE next cycle with no `done` pulse. A beat transferring in the same cycle is counted as consumed. `abort` has priority over `last` completion.
- `start` in SCAN or DONE is ignored. Input bounds changing mid-scan have no effect.
- Single-pixel window (min=max on both axes): one beat with `last`=1.
- Outputs in IDLE: `valid`=`busy`=`last`=`done`=0; `x` and `y` hold their last values (all 0 after reset).

## Timing
- After reset: `valid`=`busy`=`last`=`done`=`err`=0, `x`=`y`=0, state IDLE.
- Start latency: `start` sampled at edge N gives `valid`=1 with (x_min, y_min) after edge N; the first beat can transfer at edge N+1.
- Throughput: one coordinate per cycle while `ready`=1. A full 16×16 scan takes 256 transfer cycles.
- `done` is high during the cycle after the last transfer. `busy` falls one cycle later. The earliest restart is `start` at the edge that leaves DONE plus one cycle, i.e. `start` sampled in IDLE.
- `err` is high the cycle after the offending `start`.
- Reset asserted mid-scan: outputs clear combinationally-asynchronously. No `done` is ever produced for an interrupted scan.
- All outputs are registered; there are no combinational paths from `ready` or `start` to any output.

## Structure
- Package `raster_pkg`:
  - `W` default constant.
  - state enum `scan_state_t` {IDLE, SCAN, DONE}.
  - coordinate typedef `coord_t` (logic[W-1:0]).
- Sub-module `raster_axis_counter`, instantiated twice (x, y):
  - loadable counter with `load` and `inc` inputs and a `min`/`max` bound.
  - `at_max` flag output.
  - The x instance's `at_max` gates the y instance's `inc` and the x instance's reload.
- Top level holds the FSM, bound registers, error checking and handshake logic.

## Test plan
- Full frame: window 0..15 × 0..15, `ready`=1 → 256 beats (0,0),(1,0)…(15,0),(0,1)…(15,15); `last` only on (15,15); `done` pulse one cycle later; `busy` falls the cycle after.
- Sub-window with stalls: x 2..4, y 1..2, `ready` pattern 1,0,0,1,… → exactly 6 beats (2,1),(3,1),(4,1),(2,2),(3,2),(4,2); coordinates held during `ready`=0; no duplicates and no skips.
- Invalid window: `start` with x_min=5, x_max=3 → `err`=1 for one cycle, `valid` stays 0, state IDLE; a following valid `start` scans normally.
- Single pixel: window 7..7 × 9..9 → one beat (7,9) with `last`=1, then `done`.
- Abort: full frame, `abort` after 20 beats → IDLE next cycle, `valid`=0, no `done`; `start` during SCAN earlier in the run has no effect.
- Reset mid-scan: assert `reset` between clock edges at beat 40 → `x`=`y`=0 and `valid`=`busy`=0 immediately; after release, a new `start` begins at (x_min, y_min).
